ksa_ft_sequencer: RTL

Upstream/downstream controller wrapped around the 16-bit fault-correcting Kogge-Stone adder (kogge_16_fault_correction).
- Accepts operands on a valid/ready handshake and holds them stable at the adder.
- Drives the adder's correction_enable for exactly one 4-segment sweep, then captures corrected_sum/cout.
- Returns the result on a valid/ready handshake with fault status: speculative-vs-corrected mismatch, residual error against an internal golden sum, and a saturating fault counter.

---
 rtl/ksa_ft_pkg.sv | 15 +
 rtl/ksa_ft_status.sv | 57 +++++
 rtl/ksa_ft_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ksa_ft_pkg.sv
// Shared types and default geometry for the fault-tolerant Kogge-Stone sequencer.
package ksa_ft_pkg;

  localparam int KSA_WIDTH = 16;
  localparam int KSA_SEG_W = 4;
  localparam int KSA_SEGS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    CAPT  = 2'd2,
    OUT   = 2'd3
  } ksa_state_e;

endpackage

// File: rtl/ksa_ft_status.sv
// Golden-sum reference, speculative/corrected mismatch flags and saturating fault counter.
module ksa_ft_status
  import ksa_ft_pkg::*;
#(
  parameter int WIDTH  = KSA_WIDTH,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic              capture,
  input  logic [WIDTH-1:0]  corrected_sum,
  input  logic [WIDTH-1:0]  uncorrected_sum,
  input  logic              corrected_cout,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_cout,
  output logic              fault_detected,
  output logic              residual_error,
  output logic [FCNT_W-1:0] fault_count
);

  logic [WIDTH:0] golden;
  logic           mismatch;
  logic           residual;

  assign mismatch = (uncorrected_sum != corrected_sum);
  assign residual = ({corrected_cout, corrected_sum} != golden);

  always_ff @(posedge clk) begin
    if (rst) begin
      golden         <= '0;
      out_sum        <= '0;
      out_cout       <= 1'b0;
      fault_detected <= 1'b0;
      residual_error <= 1'b0;
      fault_count    <= '0;
    end else begin
      if (load) begin
        golden <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      end
      if (capture) begin
        out_sum        <= corrected_sum;
        out_cout       <= corrected_cout;
        fault_detected <= mismatch;
        residual_error <= residual;
        // A saturated counter stays pinned; the per-op flag still reports the fault.
        if (mismatch && (fault_count != {FCNT_W{1'b1}})) begin
          fault_count <= fault_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ksa_ft_sequencer.sv
// Handshake front/back end that drives one correction sweep of the fault-correcting adder.
//   state | meaning
//   IDLE  | ready for operands; accept latches adder inputs and golden sum
//   SWEEP | correction_enable high, one cycle per segment
//   CAPT  | settling cycle, result and status captured at its end
//   OUT   | result presented until consumer accepts
module ksa_ft_sequencer
  import ksa_ft_pkg::*;
#(
  parameter int WIDTH  = KSA_WIDTH,
  parameter int SEG_W  = KSA_SEG_W,
  parameter int SEGS   = KSA_SEGS,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_cin,
  output logic [WIDTH-1:0]  adder_a,
  output logic [WIDTH-1:0]  adder_b,
  output logic              adder_cin,
  output logic              adder_corr_en,
  input  logic [WIDTH-1:0]  adder_corrected_sum,
  input  logic [WIDTH-1:0]  adder_uncorrected_sum,
  input  logic              adder_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_cout,
  output logic              fault_detected,
  output logic              residual_error,
  output logic [FCNT_W-1:0] fault_count
);

  localparam int STEP_W = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEGS - 1);

  if (WIDTH != SEGS * SEG_W) begin : g_cfg_check
    $error("ksa_ft_sequencer: WIDTH must equal SEGS*SEG_W");
  end

  ksa_state_e        state, state_nxt;
  logic [STEP_W-1:0] step;
  logic              accept;
  logic              capture;

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    adder_corr_en = 1'b0;
    out_valid     = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SWEEP;
      end
      SWEEP: begin
        adder_corr_en = 1'b1;
        if (step == LAST_STEP) state_nxt = CAPT;
      end
      CAPT: begin
        capture   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // step tracks the adder's internal segment counter, so it only advances on enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      adder_a   <= '0;
      adder_b   <= '0;
      adder_cin <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        adder_a   <= in_a;
        adder_b   <= in_b;
        adder_cin <= in_cin;
        step      <= '0;
      end else if (adder_corr_en) begin
        step <= step + 1'b1;
      end
    end
  end

  ksa_ft_status #(
    .WIDTH  (WIDTH),
    .FCNT_W (FCNT_W)
  ) u_status (
    .clk             (clk),
    .rst             (rst),
    .load            (accept),
    .a               (in_a),
    .b               (in_b),
    .cin             (in_cin),
    .capture         (capture),
    .corrected_sum   (adder_corrected_sum),
    .uncorrected_sum (adder_uncorrected_sum),
    .corrected_cout  (adder_cout),
    .out_sum         (out_sum),
    .out_cout        (out_cout),
    .fault_detected  (fault_detected),
    .residual_error  (residual_error),
    .fault_count     (fault_count)
  );

endmodule
